ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the Y86 pipeline; sits directly downstream of decode (id).
- Consumes decoded icode/ifun, operands valA/valB, valC, valP and destination register IDs.
- Computes valE in the ALU, holds the condition-code register (ZF/SF/OF) and evaluates Cnd for cmovXX/jXX.
- Presents the results through a registered E→M pipeline boundary with stall and bubble control.

Parameters:
- DATA_W, 32, datapath width of valA/valB/valC/valP/valE.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk  in  1  stage clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode output carries a real instruction.
- id_icode  in  4  instruction code.
- id_ifun  in  4  function code.
- id_valA  in  DATA_W  operand A (register rA).
- id_valB  in  DATA_W  operand B (register rB).
- id_valC  in  DATA_W  constant word.
- id_valP  in  DATA_W  fall-through PC.
- id_dstE  in  4  ALU destination register ID.
- id_dstM  in  4  memory destination register ID.
- stall  in  1  hold all output registers.
- bubble  in  1  load a nop into the output registers.
- cc_hold  in  1  suppress CC update (downstream exception in flight).
- ex_valid  out  1  registered valid.
- ex_icode  out  4  registered icode.
- ex_cnd  out  1  registered condition result.
- ex_valE  out  DATA_W  registered ALU result.
- ex_valA  out  DATA_W  registered valA (store data / return address path).
- ex_dstE  out  4  registered dstE, already cmov-qualified.
- ex_dstM  out  4  registered dstM.
- ex_err  out  1  registered invalid-ifun flag.
- cc_o  out  3  current {ZF,SF,OF}.

Behaviour:
- Reset, asynchronous while rst=0:
  - ex_valid=0, ex_icode=4'h1 (nop), ex_cnd=0, ex_valE=0, ex_valA=0.
  - ex_dstE=ex_dstM=RNONE, ex_err=0.
  - CC={ZF=1,SF=0,OF=0}.
  - Release of reset mid-operation restarts from this bubble state.
- Latency: one clock. Inputs sampled at edge N appear on ex_* after edge N.
- Priority per edge: bubble > stall > load.
  - bubble=1: load reset values except CC, which is untouched.
  - stall=1 (bubble=0): every ex_* and the CC hold their values.
  - Otherwise: load the computed values.
- ALU operand selection by icode:
  - 2 rrmov/cmov: valA+0.
  - 3 irmov: valC+0.
  - 4 rmmov and 5 mrmov: valB+valC.
  - 6 OP: valB op valA.
  - 8 call and A push: valB+(-4).
  - 9 ret and B pop: valB+4.
  - All other icodes: valE=0.
  - All arithmetic is modulo 2^DATA_W.
- OP ifun encoding: 0 add, 1 sub (valB-valA), 2 and, 3 xor.
  - ifun>3 with icode 6: valE=0, ex_err=1, no CC update.
- CC update occurs only when all of the following hold: load (no stall/bubble), id_valid=1, icode=6, ifun≤3, cc_hold=0.
  - ZF = (t==0).
  - SF = t[MSB].
  - OF for add = (a[MSB]==b[MSB]) && (t[MSB]!=a[MSB]).
  - OF for sub = (valB[MSB]!=valA[MSB]) && (t[MSB]!=valB[MSB]).
  - OF for and/xor = 0.
- Cnd is computed from the CC value held before this edge's update, for icode 2 or 7.
  - ifun 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne !ZF, 5 ge !(SF^OF), 6 g !(SF^OF)&!ZF.
  - ifun>6: Cnd=0 and ex_err=1.
  - Other icodes: Cnd=0.
- cmov qualification: icode 2 with Cnd=0 forces ex_dstE=RNONE.
- id_valid=0 while loading: behaves exactly as bubble.
- Back-to-back OP instructions: the second instruction's Cnd/CC sees the first instruction's update, with no extra cycle.

Decomposition:
- Shared package/defines holds:
  - icode constants (IHALT..IPOPL).
  - ALU function codes (ALUADD..ALUXOR).
  - Condition codes (C_YES..C_G).
  - RNONE.
  - The CC bit indices.
- One natural sub-module: ex_alu. It is combinational and takes aluA, aluB and alufun, returning valE, zf, sf and of.
- ex_stage owns operand muxing, the CC register, Cnd logic and the output registers.

Test Plan:
- Reset: assert rst=0 mid-stream → ex_valid=0, ex_icode=1, ex_dstE=F, cc_o=3'b100, all asynchronously without waiting for a clock edge.
- Add with overflow: OP add with valA=0x7FFFFFFF, valB=1 → ex_valE=0x80000000 and CC {0,1,1}. Then OP sub with valA=5, valB=5 → valE=0, CC {1,0,0}.
- cmov: CC={0,1,0}, then cmovl (icode 2, ifun 2) with dstE=3 → ex_cnd=1, ex_dstE=3. Then cmovge → ex_cnd=0, ex_dstE=F.
- Push/pop: push with valB=0x100 → ex_valE=0xFC. Pop with valB=0x100 → 0x104. mrmov with valB=0x20, valC=8 → 0x28. No CC change in any of these.
- Stall/bubble priority: stall=1 for 2 cycles with OP input → outputs and CC are frozen. Then stall=bubble=1 → nop loaded and CC unchanged. cc_hold=1 with OP → valE correct and CC unchanged.
- Invalid codes: OP with ifun=7 → valE=0, ex_err=1, CC unchanged. jXX with ifun=9 → ex_cnd=0, ex_err=1.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared constants and types for the Y86 execute stage: instruction codes, ALU
// and condition function codes, register IDs and the E->M pipeline payload.
package ex_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CC_W   = 3;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVL = 4'h2;
  localparam logic [3:0] IIRMOVL = 4'h3;
  localparam logic [3:0] IRMMOVL = 4'h4;
  localparam logic [3:0] IMRMOVL = 4'h5;
  localparam logic [3:0] IOPL    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHL  = 4'hA;
  localparam logic [3:0] IPOPL   = 4'hB;

  typedef enum logic [1:0] {
    ALUADD = 2'd0,
    ALUSUB = 2'd1,
    ALUAND = 2'd2,
    ALUXOR = 2'd3
  } alu_fun_e;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  // cc_o packing is {ZF,SF,OF}
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;
  localparam logic [CC_W-1:0] CC_RESET = 3'b100;

  localparam logic [DATA_W-1:0] STACK_DEC = ~DATA_W'(3);
  localparam logic [DATA_W-1:0] STACK_INC = DATA_W'(4);

  typedef struct packed {
    logic              valid;
    logic [3:0]        icode;
    logic              cnd;
    logic [DATA_W-1:0] val_e;
    logic [DATA_W-1:0] val_a;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic              err;
  } ex_out_t;

  localparam ex_out_t EX_NOP = '{
    valid: 1'b0, icode: INOP, cnd: 1'b0, val_e: '0, val_a: '0,
    dst_e: RNONE, dst_m: RNONE, err: 1'b0
  };

  // Evaluate a jXX/cmovXX condition against a CC snapshot; unknown codes are false.
  function automatic logic cond_eval(input logic [3:0] ifun, input logic [CC_W-1:0] cc);
    logic zf, sf, of;
    zf = cc[CC_ZF];
    sf = cc[CC_SF];
    of = cc[CC_OF];
    case (ifun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = (sf ^ of) | zf;
      C_L:     cond_eval = sf ^ of;
      C_E:     cond_eval = zf;
      C_NE:    cond_eval = ~zf;
      C_GE:    cond_eval = ~(sf ^ of);
      C_G:     cond_eval = ~(sf ^ of) & ~zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational Y86 ALU: val_e = alu_b <op> alu_a, plus the flags the CC would take.
module ex_alu
  import ex_stage_pkg::*;
(
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  alu_fun_e          alu_fun,
  output logic [DATA_W-1:0] val_e,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  localparam int unsigned MSB = DATA_W - 1;

  always_comb begin
    val_e = '0;
    of    = 1'b0;
    case (alu_fun)
      ALUADD: begin
        val_e = alu_b + alu_a;
        of    = (alu_a[MSB] == alu_b[MSB]) && (val_e[MSB] != alu_a[MSB]);
      end
      ALUSUB: begin
        val_e = alu_b - alu_a;
        of    = (alu_b[MSB] != alu_a[MSB]) && (val_e[MSB] != alu_b[MSB]);
      end
      ALUAND: val_e = alu_b & alu_a;
      ALUXOR: val_e = alu_b ^ alu_a;
      default: val_e = '0;
    endcase
    zf = (val_e == '0);
    sf = val_e[MSB];
  end

endmodule

// File: rtl/ex_stage.sv
// Y86 execute stage: operand muxing, ALU, condition codes, Cnd evaluation and
// the registered E->M boundary with bubble/stall control.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_icode,
  input  logic [3:0]        id_ifun,
  input  logic [DATA_W-1:0] id_valA,
  input  logic [DATA_W-1:0] id_valB,
  input  logic [DATA_W-1:0] id_valC,
  input  logic [DATA_W-1:0] id_valP,
  input  logic [3:0]        id_dstE,
  input  logic [3:0]        id_dstM,
  input  logic              stall,
  input  logic              bubble,
  input  logic              cc_hold,
  output logic              ex_valid,
  output logic [3:0]        ex_icode,
  output logic              ex_cnd,
  output logic [DATA_W-1:0] ex_valE,
  output logic [DATA_W-1:0] ex_valA,
  output logic [3:0]        ex_dstE,
  output logic [3:0]        ex_dstM,
  output logic              ex_err,
  output logic [CC_W-1:0]   cc_o
);

  logic [DATA_W-1:0] alu_a, alu_b, alu_val_e;
  alu_fun_e          alu_fun;
  logic              alu_zf, alu_sf, alu_of;

  logic    op_ok, op_bad, is_cond, cond_bad, cnd_c, load;
  ex_out_t calc;
  ex_out_t out_d, out_q;
  logic [CC_W-1:0] cc_d, cc_q;

  // Operand selection; unlisted icodes leave both operands zero so val_e is zero.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = ALUADD;
    case (id_icode)
      IRRMOVL: alu_a = id_valA;
      IIRMOVL: alu_a = id_valC;
      IRMMOVL, IMRMOVL: begin
        alu_a = id_valC;
        alu_b = id_valB;
      end
      IOPL: begin
        alu_a   = id_valA;
        alu_b   = id_valB;
        alu_fun = alu_fun_e'(id_ifun[1:0]);
      end
      ICALL, IPUSHL: begin
        alu_a = STACK_DEC;
        alu_b = id_valB;
      end
      IRET, IPOPL: begin
        alu_a = STACK_INC;
        alu_b = id_valB;
      end
      default: ;
    endcase
  end

  ex_alu u_alu (
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_fun (alu_fun),
    .val_e   (alu_val_e),
    .zf      (alu_zf),
    .sf      (alu_sf),
    .of      (alu_of)
  );

  // Cnd uses the CC held before this edge, so back-to-back OPs chain naturally.
  always_comb begin
    op_ok    = (id_ifun <= 4'd3);
    op_bad   = (id_icode == IOPL) && !op_ok;
    is_cond  = (id_icode == IRRMOVL) || (id_icode == IJXX);
    cond_bad = is_cond && (id_ifun > C_G);
    cnd_c    = is_cond && !cond_bad && cond_eval(id_ifun, cc_q);
    load     = !bubble && !stall;

    calc       = EX_NOP;
    calc.valid = 1'b1;
    calc.icode = id_icode;
    calc.cnd   = cnd_c;
    calc.val_e = op_bad ? '0 : alu_val_e;
    calc.val_a = id_valA;
    calc.dst_e = ((id_icode == IRRMOVL) && !cnd_c) ? RNONE : id_dstE;
    calc.dst_m = id_dstM;
    calc.err   = op_bad || cond_bad;
  end

  // Next-state: bubble > stall > load; an invalid decode slot loads a nop.
  always_comb begin
    out_d = out_q;
    cc_d  = cc_q;
    if (bubble) begin
      out_d = EX_NOP;
    end else if (!stall) begin
      out_d = id_valid ? calc : EX_NOP;
    end
    if (load && id_valid && (id_icode == IOPL) && op_ok && !cc_hold) begin
      cc_d = {alu_zf, alu_sf, alu_of};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= EX_NOP;
      cc_q  <= CC_RESET;
    end else begin
      out_q <= out_d;
      cc_q  <= cc_d;
    end
  end

  assign ex_valid = out_q.valid;
  assign ex_icode = out_q.icode;
  assign ex_cnd   = out_q.cnd;
  assign ex_valE  = out_q.val_e;
  assign ex_valA  = out_q.val_a;
  assign ex_dstE  = out_q.dst_e;
  assign ex_dstM  = out_q.dst_m;
  assign ex_err   = out_q.err;
  assign cc_o     = cc_q;

  // valP is forwarded by the pipeline around this stage and is not used here.
  logic unused_valp;
  assign unused_valp = ^id_valP;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with hand-computed expected values.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_icode, id_ifun, id_dstE, id_dstM;
  logic [31:0] id_valA, id_valB, id_valC, id_valP;
  logic        stall, bubble, cc_hold;
  logic        ex_valid, ex_cnd, ex_err;
  logic [3:0]  ex_icode, ex_dstE, ex_dstM;
  logic [31:0] ex_valE, ex_valA;
  logic [2:0]  cc_o;

  int checks = 0;
  int errors = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_icode(id_icode), .id_ifun(id_ifun),
    .id_valA(id_valA), .id_valB(id_valB), .id_valC(id_valC), .id_valP(id_valP),
    .id_dstE(id_dstE), .id_dstM(id_dstM), .stall(stall), .bubble(bubble), .cc_hold(cc_hold),
    .ex_valid(ex_valid), .ex_icode(ex_icode), .ex_cnd(ex_cnd), .ex_valE(ex_valE),
    .ex_valA(ex_valA), .ex_dstE(ex_dstE), .ex_dstM(ex_dstM), .ex_err(ex_err), .cc_o(cc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [3:0] de, input logic [3:0] dm);
    id_valid = 1'b1;
    id_icode = icode;
    id_ifun  = ifun;
    id_valA  = a;
    id_valB  = b;
    id_valC  = c;
    id_valP  = 32'h0000_1000;
    id_dstE  = de;
    id_dstM  = dm;
  endtask

  task automatic issue(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [3:0] de, input logic [3:0] dm);
    drive(icode, ifun, a, b, c, de, dm);
    step();
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0; bubble = 1'b0; cc_hold = 1'b0;
    drive(4'h1, 4'h0, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF);
    id_valid = 1'b0;
    #12;
    check("rst_valid", 64'(ex_valid), 64'h0);
    check("rst_icode", 64'(ex_icode), 64'h1);
    check("rst_dstE",  64'(ex_dstE),  64'hF);
    check("rst_dstM",  64'(ex_dstM),  64'hF);
    check("rst_valE",  64'(ex_valE),  64'h0);
    check("rst_cc",    64'(cc_o),     64'h4);
    @(negedge clk);
    rst = 1'b1;

    // add overflow, then sub to zero
    issue(4'h6, 4'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 4'h2, 4'hF);
    check("add_valE",  64'(ex_valE),  64'h8000_0000);
    check("add_cc",    64'(cc_o),     64'h3);
    check("add_valid", 64'(ex_valid), 64'h1);
    check("add_icode", 64'(ex_icode), 64'h6);
    issue(4'h6, 4'h1, 32'h5, 32'h5, 32'h0, 4'h2, 4'hF);
    check("sub0_valE", 64'(ex_valE), 64'h0);
    check("sub0_cc",   64'(cc_o),    64'h4);

    // 3-5 = -2 gives CC {0,1,0}
    issue(4'h6, 4'h1, 32'h5, 32'h3, 32'h0, 4'h2, 4'hF);
    check("subn_valE", 64'(ex_valE), 64'hFFFF_FFFE);
    check("subn_cc",   64'(cc_o),    64'h2);

    issue(4'h2, 4'h2, 32'h55, 32'h0, 32'h0, 4'h3, 4'hF);
    check("cmovl_cnd",  64'(ex_cnd),  64'h1);
    check("cmovl_dstE", 64'(ex_dstE), 64'h3);
    check("cmovl_valE", 64'(ex_valE), 64'h55);
    issue(4'h2, 4'h5, 32'h55, 32'h0, 32'h0, 4'h3, 4'hF);
    check("cmovge_cnd",  64'(ex_cnd),  64'h0);
    check("cmovge_dstE", 64'(ex_dstE), 64'hF);

    issue(4'hA, 4'h0, 32'h9, 32'h100, 32'h0, 4'h4, 4'hF);
    check("push_valE", 64'(ex_valE), 64'hFC);
    check("push_valA", 64'(ex_valA), 64'h9);
    issue(4'hB, 4'h0, 32'h0, 32'h100, 32'h0, 4'h4, 4'h6);
    check("pop_valE", 64'(ex_valE), 64'h104);
    issue(4'h5, 4'h0, 32'h0, 32'h20, 32'h8, 4'hF, 4'h5);
    check("mrmov_valE", 64'(ex_valE), 64'h28);
    check("mrmov_dstM", 64'(ex_dstM), 64'h5);
    check("mem_cc",     64'(cc_o),    64'h2);

    // stall holds everything including CC
    stall = 1'b1;
    drive(4'h6, 4'h0, 32'h1, 32'h1, 32'h0, 4'h1, 4'hF);
    for (int i = 0; i < 2; i++) begin
      step();
      check("stall_valE",  64'(ex_valE),  64'h28);
      check("stall_icode", 64'(ex_icode), 64'h5);
      check("stall_cc",    64'(cc_o),     64'h2);
    end
    bubble = 1'b1;
    step();
    check("bub_valid", 64'(ex_valid), 64'h0);
    check("bub_icode", 64'(ex_icode), 64'h1);
    check("bub_dstE",  64'(ex_dstE),  64'hF);
    check("bub_cc",    64'(cc_o),     64'h2);
    stall = 1'b0; bubble = 1'b0;

    cc_hold = 1'b1;
    issue(4'h6, 4'h0, 32'h1, 32'h1, 32'h0, 4'h1, 4'hF);
    check("hold_valE", 64'(ex_valE), 64'h2);
    check("hold_cc",   64'(cc_o),    64'h2);
    cc_hold = 1'b0;

    // back-to-back: xor sets ZF, je immediately after sees it
    issue(4'h6, 4'h3, 32'h7, 32'h7, 32'h0, 4'h1, 4'hF);
    check("xor_valE", 64'(ex_valE), 64'h0);
    check("xor_cc",   64'(cc_o),    64'h4);
    issue(4'h7, 4'h3, 32'h0, 32'h0, 32'h40, 4'hF, 4'hF);
    check("je_cnd", 64'(ex_cnd), 64'h1);
    check("je_err", 64'(ex_err), 64'h0);

    issue(4'h6, 4'h7, 32'h1, 32'h2, 32'h0, 4'h1, 4'hF);
    check("badop_valE", 64'(ex_valE), 64'h0);
    check("badop_err",  64'(ex_err),  64'h1);
    check("badop_cc",   64'(cc_o),    64'h4);
    issue(4'h7, 4'h9, 32'h0, 32'h0, 32'h40, 4'hF, 4'hF);
    check("badj_cnd", 64'(ex_cnd), 64'h0);
    check("badj_err", 64'(ex_err), 64'h1);

    issue(4'h6, 4'h2, 32'hF0, 32'h3C, 32'h0, 4'h1, 4'hF);
    check("and_valE", 64'(ex_valE), 64'h30);
    check("and_cc",   64'(cc_o),    64'h0);

    drive(4'h6, 4'h1, 32'h5, 32'h5, 32'h0, 4'h1, 4'hF);
    id_valid = 1'b0;
    step();
    check("inv_valid", 64'(ex_valid), 64'h0);
    check("inv_icode", 64'(ex_icode), 64'h1);
    check("inv_cc",    64'(cc_o),     64'h0);

    // asynchronous reset mid-stream, no clock edge between assert and check
    issue(4'h6, 4'h0, 32'h1, 32'h1, 32'h0, 4'h2, 4'hF);
    check("pre_rst_valid", 64'(ex_valid), 64'h1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(ex_valid), 64'h0);
    check("arst_icode", 64'(ex_icode), 64'h1);
    check("arst_dstE",  64'(ex_dstE),  64'hF);
    check("arst_cc",    64'(cc_o),     64'h4);
    @(negedge clk);
    rst = 1'b1;
    issue(4'h3, 4'h0, 32'h0, 32'h0, 32'h1234, 4'h7, 4'hF);
    check("irmov_valE", 64'(ex_valE), 64'h1234);
    check("irmov_dstE", 64'(ex_dstE), 64'h7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
